// File: rtl/sub_bytes_seq.sv
// Sequential forward AES SubBytes: BPC bytes per clock behind a start/busy/done handshake.
// Optional macro SUB_BYTES_SHIFTROWS_EN folds ShiftRows into the completion result.
module sub_bytes_seq #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  localparam int N  = 16 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
  end

  // Forward Rijndael S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [127:0]    work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [127:0]    out_q, out_d;
  logic [127:0]    work_sub_s;
  logic [127:0]    result_s;

  // Substitute the BPC bytes selected by the counter.
  always_comb begin
    work_sub_s = work_q;
    for (int j = 0; j < BPC; j++) begin
      work_sub_s[127 - 8*(int'(cnt_q)*BPC + j) -: 8] =
        sbox(work_q[127 - 8*(int'(cnt_q)*BPC + j) -: 8]);
    end
  end

`ifdef SUB_BYTES_SHIFTROWS_EN
  // Row r (byte index i with i%4 == r) rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = s[127 - 8*(4*(((i/4) + (i%4)) % 4) + (i%4)) -: 8];
    end
    return r;
  endfunction

  assign result_s = shift_rows(work_sub_s);
`else
  assign result_s = work_sub_s;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = IDLE;
        else               state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output and datapath next values.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    out_d  = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = state_in;
          cnt_d  = {CW{1'b0}};
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      RUN: begin
        work_d = work_sub_s;
        if (cnt_q == LAST) begin
          out_d  = result_s;
          cnt_d  = {CW{1'b0}};
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CW'(1'b1);
          busy_d = 1'b1;
        end
      end
      default: begin
        cnt_d  = {CW{1'b0}};
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= 128'h0;
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= 128'h0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq at BPC = 1, 4 and 16 driven side by side.
module tb_sub_bytes_seq;

  typedef struct {
    int           dut;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] state_in;
  logic         start_a [3];
  logic         busy_a  [3];
  logic         done_a  [3];
  logic [127:0] out_a   [3];

  int   n_of [3] = '{16, 4, 1};
  exp_t sb_q [$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  logic [7:0] gold [256];

  localparam logic [127:0] T1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef SUB_BYTES_SHIFTROWS_EN
  localparam logic [127:0] T1_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
  localparam logic [127:0] T1_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_seq #(.BPC(1)) u_bpc1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .state_in(state_in),
    .busy(busy_a[0]), .done(done_a[0]), .state_out(out_a[0]));
  sub_bytes_seq #(.BPC(4)) u_bpc4 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .state_in(state_in),
    .busy(busy_a[1]), .done(done_a[1]), .state_out(out_a[1]));
  sub_bytes_seq #(.BPC(16)) u_bpc16 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .state_in(state_in),
    .busy(busy_a[2]), .done(done_a[2]), .state_out(out_a[2]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Golden S-box from GF(2^8) inverse plus affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (a != 8'h00 && gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation of that DUT.
  always @(negedge clk) begin
    int idx;
    for (int d = 0; d < 3; d++) begin
      if (done_a[d] === 1'b1) begin
        idx = -1;
        foreach (sb_q[k]) if (idx < 0 && sb_q[k].dut == d) idx = k;
        if (idx < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done dut%0d: done=1 at cycle %0d, none pending", d, cyc);
        end else begin
          chk($sformatf("result_dut%0d", d), out_a[d], sb_q[idx].data);
          chk($sformatf("latency_dut%0d", d), 128'(cyc), 128'(sb_q[idx].cyc));
          chk($sformatf("busy_at_done_dut%0d", d), 128'(busy_a[d]), 128'h0);
          sb_q.delete(idx);
        end
      end
    end
  end

  task automatic launch(input logic [2:0] mask, input logic [127:0] v, input logic [127:0] e);
    exp_t x;
    @(negedge clk);
    state_in = v;
    for (int d = 0; d < 3; d++) begin
      start_a[d] = mask[d];
      if (mask[d]) begin
        x.dut = d; x.data = e; x.cyc = cyc + 1 + n_of[d];
        sb_q.push_back(x);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) start_a[d] = 1'b0;
    state_in = ~v;
  endtask

  task automatic wait_idle(input logic [2:0] mask, input int budget);
    int k;
    k = 0;
    while (k < budget && ((mask[0] && busy_a[0]) || (mask[1] && busy_a[1]) || (mask[2] && busy_a[2]))) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: still busy after %0d cycles, mask %b", budget, mask);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t x;
    for (int b = 0; b < 256; b++) gold[b] = sbox_ref(8'(b));

    rst_n    = 1'b0;
    state_in = 128'h0;
    for (int d = 0; d < 3; d++) start_a[d] = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_busy_dut%0d", d), 128'(busy_a[d]), 128'h0);
      chk($sformatf("reset_done_dut%0d", d), 128'(done_a[d]), 128'h0);
      chk($sformatf("reset_out_dut%0d", d), out_a[d], 128'h0);
    end
    rst_n = 1'b1;

    // FIPS-197 round vector and uniform states on all three widths.
    launch(3'b111, T1_IN, T1_EXP);
    wait_idle(3'b111, 20);
    launch(3'b111, 128'h0, {16{8'h63}});
    wait_idle(3'b111, 20);
    launch(3'b111, {16{8'h53}}, {16{8'hed}});
    wait_idle(3'b111, 20);
    launch(3'b111, {16{8'hff}}, {16{8'h16}});
    wait_idle(3'b111, 20);

    // start while busy is ignored.
    launch(3'b010, T1_IN, T1_EXP);
    @(negedge clk);
    start_a[1] = 1'b1;
    state_in   = 128'h0;
    @(negedge clk);
    start_a[1] = 1'b0;
    chk("busy_during_ignored_start", 128'(busy_a[1]), 128'h1);
    wait_idle(3'b010, 10);
    repeat (6) @(negedge clk);
    chk("idle_after_ignored_start", 128'(busy_a[1]), 128'h0);
    chk("out_hold_after_run", out_a[1], T1_EXP);

    // start in the done cycle; previous result holds meanwhile.
    launch(3'b010, {16{8'h53}}, {16{8'hed}});
    k = 0;
    while (k < 10 && done_a[1] !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen_for_b2b", 128'(done_a[1]), 128'h1);
    state_in   = {16{8'hff}};
    start_a[1] = 1'b1;
    x.dut = 1; x.data = {16{8'h16}}; x.cyc = cyc + 1 + n_of[1];
    sb_q.push_back(x);
    @(negedge clk);
    start_a[1] = 1'b0;
    state_in   = 128'h0;
    for (int j = 0; j < 3; j++) begin
      chk("b2b_out_hold", out_a[1], {16{8'hed}});
      chk("b2b_busy", 128'(busy_a[1]), 128'h1);
      @(negedge clk);
    end
    wait_idle(3'b010, 10);

    // Reset mid-run aborts with no done.
    launch(3'b010, 128'h0, {16{8'h63}});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 128'(busy_a[1]), 128'h0);
    chk("abort_done", 128'(done_a[1]), 128'h0);
    chk("abort_out", out_a[1], 128'h0);
    rst_n = 1'b1;
    for (int i = sb_q.size() - 1; i >= 0; i--) if (sb_q[i].dut == 1) sb_q.delete(i);
    repeat (8) @(negedge clk);
    launch(3'b010, T1_IN, T1_EXP);
    wait_idle(3'b010, 10);

    // Every byte value through position 0 at all widths.
    for (int b = 0; b < 256; b++) begin
      launch(3'b111, {8'(b), 120'h0}, {gold[b], {15{8'h63}}});
      wait_idle(3'b111, 20);
    end

    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_done: %0d expected results never appeared", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
